// File: rtl/wb_mem_master.sv
// Wishbone classic initiator: turns one picorv32 native memory request into a single
// Wishbone transfer, terminated by ack, err or a bounded timeout.
module wb_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_instr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        instr_q, instr_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TimeoutLast);

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    instr_d   = instr_q;
    ready_d   = ready_q;
    error_d   = error_q;
    rdata_d   = rdata_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          adr_d   = mem_addr;
          dat_d   = mem_wdata;
          instr_d = mem_instr;
          we_d    = |mem_wstrb;
          sel_d   = (|mem_wstrb) ? mem_wstrb : 4'b1111;
          cyc_d   = 1'b1;
          tcnt_d  = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        tcnt_d = tcnt_q + 32'd1;
        if (wbm_err_i || wbm_ack_i || timeout_hit) begin
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          state_d = StResp;
          // err outranks ack; timeout only matters when the responder stays silent
          if (wbm_err_i || !wbm_ack_i) begin
            error_d = 1'b1;
            rdata_d = ERR_DATA;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else if (!we_q) begin
            rdata_d = wbm_dat_i;
          end
        end
      end
      StResp: begin
        ready_d = 1'b0;
        error_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= StIdle;
      tcnt_q    <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      instr_q   <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      instr_q   <= instr_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rdata_q   <= rdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // cyc and stb share one register so they can never diverge
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_we_o    = we_q;
  assign wbm_instr_o = instr_q;
  assign mem_ready   = ready_q;
  assign mem_error   = error_q;
  assign mem_rdata   = rdata_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_wb_mem_master.sv
// Scoreboard bench for wb_mem_master: directed requests push expected responses, a
// monitor pops and compares on every mem_ready pulse.
module tb_wb_mem_master;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, mem_error, we, cyc, stb, instr;
  logic [31:0] mem_rdata, adr, dat;
  logic [3:0]  sel;
  logic [7:0]  err_count;

  logic [31:0] resp_data = '0;
  logic        resp_ack  = 1'b0;
  logic        resp_err  = 1'b0;
  logic        stray_ack = 1'b0;
  logic        ack;
  int          resp_kind = 0;  // 0 ack, 1 err, 2 ack+err, 3 silent
  int          resp_wait = 0;
  assign ack = resp_ack | stray_ack;

  wb_mem_master #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_instr_o(instr),
    .wbm_dat_i(resp_data), .wbm_ack_i(ack), .wbm_err_i(resp_err),
    .err_count(err_count)
  );

  // Second instance with the timeout disabled, never answered.
  logic        v2 = 1'b0;
  logic        ready2, error2, we2, cyc2, stb2, instr2;
  logic [31:0] rdata2, adr2, dat2;
  logic [3:0]  sel2;
  logic [7:0]  cnt2;

  wb_mem_master #(.TIMEOUT_CYCLES(0), .ERR_DATA(32'hFFFF_FFFF)) dut_nto (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .mem_valid(v2), .mem_instr(1'b0), .mem_addr(32'h0000_0400),
    .mem_wdata(32'h0), .mem_wstrb(4'h0),
    .mem_ready(ready2), .mem_rdata(rdata2), .mem_error(error2),
    .wbm_adr_o(adr2), .wbm_dat_o(dat2), .wbm_sel_o(sel2), .wbm_we_o(we2),
    .wbm_cyc_o(cyc2), .wbm_stb_o(stb2), .wbm_instr_o(instr2),
    .wbm_dat_i(32'h0), .wbm_ack_i(1'b0), .wbm_err_i(1'b0),
    .err_count(cnt2)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Registered responder: answers resp_wait cycles after the first stb cycle.
  int wcnt = 0;
  bit done = 1'b0;
  always @(posedge clk) begin
    #1;
    resp_ack = 1'b0;
    resp_err = 1'b0;
    if (cyc === 1'b1 && !done) begin
      wcnt++;
      if (wcnt == resp_wait + 2) begin
        done = 1'b1;
        case (resp_kind)
          0: resp_ack = 1'b1;
          1: resp_err = 1'b1;
          2: begin resp_ack = 1'b1; resp_err = 1'b1; end
          default: done = 1'b0;
        endcase
      end
    end else if (cyc !== 1'b1) begin
      wcnt = 0;
      done = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (mem_ready === 1'b1) begin
      n_ready++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got ready=1 expected none pending");
      end else begin
        e = sb.pop_front();
        check("rdata", mem_rdata, e.rdata);
        check("error", 32'(mem_error), 32'(e.err));
        check("err_count", 32'(err_count), 32'(e.cnt));
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic ins, input int kind, input int wt, input logic [31:0] rd,
                      input logic [31:0] exp_rd, input logic exp_e, input logic [7:0] exp_c,
                      input int exp_stb, input bit keep, output int gap);
    exp_t e;
    int   cnt;
    bit   held;
    logic [3:0] exp_sel;
    exp_sel   = (ws != 4'h0) ? ws : 4'b1111;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_instr = ins;
    mem_valid = 1'b1;
    resp_kind = kind;
    resp_wait = wt;
    resp_data = rd;
    e.rdata = exp_rd;
    e.err   = exp_e;
    e.cnt   = exp_c;
    sb.push_back(e);
    gap = 0;
    while (stb !== 1'b1 && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    check("stb_rise", 32'(stb), 32'd1);
    cnt  = 0;
    held = 1'b1;
    while (stb === 1'b1 && cnt < 2000) begin
      if (adr !== a || dat !== wd || sel !== exp_sel || we !== (ws != 4'h0) ||
          cyc !== 1'b1 || instr !== ins) held = 1'b0;
      cnt++;
      @(negedge clk);
    end
    check("bus_held", 32'(held), 32'd1);
    check("stb_cycles", 32'(cnt), 32'(exp_stb));
    check("ready_latency", 32'(mem_ready), 32'd1);
    if (!keep) mem_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int n;
    #12;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    xfer(32'h0000_0100, 32'h0, 4'h0, 1'b1, 0, 0, 32'h1234_5678,
         32'h1234_5678, 1'b0, 8'd0, 2, 1'b0, gap);
    xfer(32'h1000_0000, 32'h0000_0041, 4'b0001, 1'b0, 0, 0, 32'hDEAD_BEEF,
         32'h1234_5678, 1'b0, 8'd0, 2, 1'b0, gap);
    xfer(32'h0000_0104, 32'h0, 4'h0, 1'b0, 1, 3, 32'h1111_1111,
         32'hFFFF_FFFF, 1'b1, 8'd1, 5, 1'b0, gap);
    xfer(32'h0000_0108, 32'h0, 4'h0, 1'b0, 2, 0, 32'h2222_2222,
         32'hFFFF_FFFF, 1'b1, 8'd2, 2, 1'b0, gap);
    xfer(32'h0000_010C, 32'h0, 4'h0, 1'b0, 3, 0, 32'h3333_3333,
         32'hFFFF_FFFF, 1'b1, 8'd3, 8, 1'b0, gap);

    // Stray ack while idle
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_cyc", 32'(cyc), 32'd0);
    check("stray_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    check("stray_ready2", 32'(mem_ready), 32'd0);
    check("stray_err_count", 32'(err_count), 32'd3);

    // Back-to-back with mem_valid held
    for (int i = 0; i < 4; i++) begin
      xfer(32'h0000_0200 + 32'(i * 4), 32'h0, 4'h0, 1'b0, 0, 0, 32'hA000_0000 + 32'(i),
           32'hA000_0000 + 32'(i), 1'b0, 8'd3, 2, 1'b1, gap);
      if (i > 0) check("b2b_gap_ge2", 32'(gap >= 2), 32'd1);
    end
    mem_valid = 1'b0;

    // Timeout disabled: stb must stay up
    v2 = 1'b1;
    n = 0;
    while (stb2 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (stb2 === 1'b1 && ready2 === 1'b0) n++;
    end
    check("no_timeout_stb", 32'(n), 32'd1000);
    v2 = 1'b0;

    // Async reset mid-transfer
    mem_addr  = 32'h0000_0300;
    mem_wstrb = 4'h0;
    resp_kind = 3;
    mem_valid = 1'b1;
    n = 0;
    while (stb !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_stb", 32'(stb), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_cyc", 32'(cyc), 32'd0);
    check("rst_mid_stb_low", 32'(stb), 32'd0);
    check("rst_mid_ready", 32'(mem_ready), 32'd0);
    check("rst_mid_err_count", 32'(err_count), 32'd0);
    sb.delete();
    mem_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    xfer(32'h0000_0300, 32'h0, 4'h0, 1'b0, 0, 0, 32'h55AA_55AA,
         32'h55AA_55AA, 1'b0, 8'd0, 2, 1'b0, gap);

    repeat (3) @(negedge clk);
    check("ready_total", 32'(n_ready), 32'd10);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_master.md
Name: wb_mem_master

Overview:
- Wishbone classic initiator that turns a picorv32 native memory request into one Wishbone single transfer.
- Sits between the core's native mem_* interface and Wishbone responders such as the on-chip RAM.
- Drives the wbm_* master side; bounds each transfer with error and timeout termination.
- Keeps a saturating error counter for the bench and debug.

Parameters:
TIMEOUT_CYCLES, 256, cycles in BUS without ack/err before forced termination; 0 disables timeout.
ERR_DATA, 32'hFFFF_FFFF, value returned on mem_rdata for an errored or timed-out read.

Ports:
wb_clk_i  in  1  clock.
wb_rstn_i  in  1  reset, asynchronous, active-low.
mem_valid  in  1  native request valid.
mem_instr  in  1  request is an instruction fetch.
mem_addr  in  32  byte address.
mem_wdata  in  32  write data.
mem_wstrb  in  4  byte strobes; 0 means read.
mem_ready  out  1  one-cycle completion pulse.
mem_rdata  out  32  read data, valid while mem_ready=1.
mem_error  out  1  qualifies mem_ready: transfer ended by err or timeout.
wbm_adr_o  out  32  Wishbone address (byte address, unmodified).
wbm_dat_o  out  32  Wishbone write data.
wbm_sel_o  out  4  byte selects.
wbm_we_o  out  1  write enable.
wbm_cyc_o  out  1  cycle.
wbm_stb_o  out  1  strobe.
wbm_instr_o  out  1  sideband copy of the latched mem_instr.
wbm_dat_i  in  32  read data.
wbm_ack_i  in  1  acknowledge.
wbm_err_i  in  1  error termination.
err_count  out  8  saturating count of err and timeout terminations.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 (mem_rdata=0, err_count=0); timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, BUS, RESP.
- IDLE, on mem_valid=1 at an edge:
  - latch adr=mem_addr, dat=mem_wdata, instr=mem_instr.
  - we=|mem_wstrb; sel=mem_wstrb if we=1, else 4'b1111.
  - go to BUS; cyc=stb=1 from the next cycle. Request-to-bus latency is 1 cycle.
- BUS:
  - adr, dat, sel, we, cyc and stb are held stable.
  - timeout counter increments each cycle in BUS; cleared on entry to BUS.
  - Terminating condition, priority err > ack > timeout:
    - wbm_err_i=1: error termination.
    - wbm_ack_i=1: normal termination; for reads mem_rdata <= wbm_dat_i, for writes mem_rdata is unchanged.
    - TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES-1 with no ack/err: timeout termination.
  - On any termination: next cycle cyc=stb=0, mem_ready=1, go to RESP.
  - Err/timeout: mem_error=1, mem_rdata=ERR_DATA, err_count+1 saturating at 255.
- RESP (exactly one cycle):
  - mem_ready=1; mem_valid is not sampled; ack/err are ignored.
  - next state IDLE with mem_ready=0, mem_error=0.
- Ack-to-ready latency: 1 cycle.
  - Minimum transfer against a responder with registered 1-cycle ack: valid sampled at edge N, stb high N+1, ack at N+2, ready at N+3.
  - Next request may be accepted at the edge ending the cycle after RESP.
- wbm_ack_i/wbm_err_i while not in BUS: ignored, no state change.
- mem_valid deasserted during BUS: protocol violation; the transfer still completes normally, including the mem_ready pulse.
- cyc and stb are always asserted and deasserted together; never more than one outstanding transfer.
- Async reset mid-transfer: cyc/stb drop immediately; no mem_ready is produced; err_count clears.

Test Plan:
- Read: mem_addr=0x0000_0100, wstrb=0, responder acks one cycle after stb with 0x1234_5678 -> sel=1111, we=0, cyc/stb high exactly 2 cycles, mem_ready one cycle later with rdata=0x1234_5678, mem_error=0.
- Byte write: addr=0x1000_0000, wdata=0x0000_0041, wstrb=0001 -> we=1, sel=0001, dat_o=0x41 held until ack, single mem_ready pulse, mem_rdata unchanged.
- Error: read answered with wbm_err_i=1 after 3 wait states -> mem_ready+mem_error one cycle, rdata=0xFFFF_FFFF, err_count 0->1; ack and err in the same cycle -> treated as error.
- Timeout (TIMEOUT_CYCLES=8), responder never responds -> stb high exactly 8 cycles, then mem_ready+mem_error, err_count increments; with TIMEOUT_CYCLES=0 stb stays high for 1000 cycles.
- Back-to-back: mem_valid held continuously for 4 requests against a 1-cycle-ack RAM -> 4 distinct bus cycles with cyc low for at least 2 cycles between them, 4 mem_ready pulses; stray ack injected while in IDLE is ignored.
- Reset: wb_rstn_i pulled low while in BUS -> cyc/stb/mem_ready drop in the same cycle without a clock edge; after release a new read completes normally; err_count=0.
